// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared note-RAM constants and loader state encoding
package note_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         NOTE_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - reloadable inter-byte down-counter with expiry pulse
module byte_timeout #(
    parameter int TIMEOUT = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = CNT_W'(TIMEOUT);
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Expiry wins over a reload arriving in the same cycle.
    assign o_expired = i_en && (cnt_q == CNT_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_ram_loader.sv
// rtl/note_ram_loader.sv - parses framed song images from a byte stream into note RAM
module note_ram_loader
    import note_pkg::*;
#(
    parameter int DEPTH   = 17,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_byte_stb,
    input  logic [7:0]        i_byte,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [NOTE_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done_stb,
    output logic              o_err_stb,
    output logic [ADDR_W:0]   o_song_len
);

    localparam int LEN_W = ADDR_W + 1;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          ck_q, ck_d;
    logic [7:0]          hi_q, hi_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [NOTE_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    song_len_q, song_len_d;
    logic                tmo_expired;
    logic                last_word;
    logic                n_bad;

    byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (i_byte_stb),
        .i_en      (state_q != ST_IDLE),
        .o_expired (tmo_expired)
    );

    // Address holds on the final word so it never reaches DEPTH.
    assign last_word = ((LEN_W'(addr_q) + 1'b1) == n_q);
    assign n_bad     = (i_byte == 8'd0) || ({24'd0, i_byte} > 32'(DEPTH));

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        addr_d     = addr_q;
        ck_d       = ck_q;
        hi_d       = hi_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        song_len_d = song_len_q;
        if (tmo_expired) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            song_len_d = '0;
        end else if (i_byte_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_byte == SYNC_BYTE) state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (n_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        n_d        = LEN_W'(i_byte);
                        addr_d     = '0;
                        ck_d       = i_byte;
                        song_len_d = '0;
                        state_d    = ST_HI;
                    end
                end
                ST_HI: begin
                    hi_d    = i_byte;
                    ck_d    = ck_q ^ i_byte;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {hi_q, i_byte};
                    ck_d      = ck_q ^ i_byte;
                    if (last_word) begin
                        state_d = ST_CHECK;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_HI;
                    end
                end
                ST_CHECK: begin
                    if (i_byte == ck_q) begin
                        song_len_d = n_q;
                        done_d     = 1'b1;
                    end else begin
                        song_len_d = '0;
                        err_d      = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            addr_q     <= '0;
            ck_q       <= '0;
            hi_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            song_len_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            ck_q       <= ck_d;
            hi_q       <= hi_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            song_len_q <= song_len_d;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done_stb = done_q;
    assign o_err_stb  = err_q;
    assign o_song_len = song_len_q;

endmodule
